pingpong_count_ctrl: RTL
========================

PINGPONG_COUNT_CTRL -- requirements
Module: pingpong_count_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_SHIFT, default 20, which sets the minimum tick-period exponent (benches set 1).
REQ-002 The block SHALL have parameter DWELL, default 4, range 1..255, giving the ticks held at each endpoint.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port En, input, 1 bit: run enable; 0 pauses the block.
REQ-006 The block SHALL have port SW, input, 3 bits: speed select; tick period P = 2^(BASE_SHIFT+SW) clk cycles.
REQ-007 The block SHALL have port start, input, 1 bit: synchronous start/restart request, sampled every edge.
REQ-008 The block SHALL have port stop, input, 1 bit: synchronous stop request.
REQ-009 The block SHALL have ports lo and hi, input, 8 bits each: lower and upper count bounds, unsigned.
REQ-010 The block SHALL have port LED, output, 8 bits: registered count value.
REQ-011 The block SHALL have port Dao, output, 8 bits: always ~LED.
REQ-012 The block SHALL have port dir, output, 1 bit: 1 in IDLE, UP and DWELL_LO; 0 in DOWN and DWELL_HI.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.
REQ-014 The block SHALL have port tick, output, 1 bit: a one-cycle pulse marking a step opportunity.

Function
REQ-015 The FSM SHALL have states IDLE, UP, DWELL_HI, DOWN, DWELL_LO; the clock-enable tick SHALL be the only pacing (no gated or derived clocks).
REQ-016 The prescaler SHALL count 0..P-1 only while busy=1 and En=1, assert tick when it equals P-1 with En=1, and return to 0 on that edge.
REQ-017 The prescaler SHALL clear to 0 in IDLE, on an accepted start, and on any edge where SW differs from its value at the previous edge.
REQ-018 With stop=0 and start=1, the block SHALL load LED=lo, enter UP and clear the prescaler from any state, so the first LED step occurs P edges later.
REQ-019 stop=1 SHALL force IDLE with LED held; when start and stop are both 1, stop SHALL win.
REQ-020 In UP on tick: if LED<hi, LED SHALL become LED+1, and if LED+1==hi the FSM SHALL enter DWELL_HI on the same edge; if LED>=hi, LED SHALL be unchanged and the FSM SHALL enter DWELL_HI.
REQ-021 In DOWN on tick: if LED>lo, LED SHALL become LED-1, and if LED-1==lo the FSM SHALL enter DWELL_LO on the same edge; if LED<=lo, LED SHALL be unchanged and the FSM SHALL enter DWELL_LO.
REQ-022 DWELL_HI and DWELL_LO SHALL hold LED, count ticks from 0, and exit to DOWN or UP respectively on the DWELL-th tick.
REQ-023 LED SHALL never wrap past 0 or 255; when lo>=hi, LED SHALL stay constant while the FSM cycles UP -> DWELL_HI -> DOWN -> DWELL_LO.
REQ-024 En=0 SHALL freeze the prescaler, the dwell count, the state and LED, and suppress tick; start and stop SHALL remain effective while En=0.
REQ-025 lo and hi SHALL be sampled live at each tick; changing them mid-run SHALL take effect at the next tick per REQ-020/021.

Reset
REQ-026 While reset=0, asynchronously: state=IDLE, LED=0x00, Dao=0xFF, dir=1, busy=0, tick=0, and the prescaler, dwell count and SW history SHALL all be 0.
REQ-027 Reset deassertion SHALL take effect at the next clk edge, and the block SHALL remain in IDLE until start.

Verification (BASE_SHIFT=1, DWELL=2)
REQ-028 Reset mid-run (LED=0x05, UP) -> reset=0 asserted between edges -> LED=0x00, Dao=0xFF, busy=0, dir=1 immediately, with no clk edge.
REQ-029 lo=3, hi=6, SW=0 (P=2), En=1, start pulse -> LED 3,4,5,6 changing every 2 cycles -> DWELL_HI for 4 cycles -> 5,4,3 -> DWELL_LO for 4 cycles -> 4; dir=0 from the edge LED reaches 6.
REQ-030 Running in UP with SW=0, En=0 for 10 cycles -> LED, state and prescaler unchanged, tick=0 -> after En=1 the remaining prescaler count completes before the next step.
REQ-031 In UP, SW changes 0->2 -> prescaler clears -> next LED step exactly 8 edges after the change edge.
REQ-032 lo=hi=9, start -> LED stays 9 permanently; dir toggles 1->0 after 1 tick (P=2), then toggles every 3 ticks (UP/DOWN 1 tick + dwell 2 ticks).
REQ-033 start and stop asserted on the same edge while running at LED=0x07 -> IDLE, busy=0, LED stays 0x07; a later start alone -> LED=lo, busy=1.

Source files
------------

// File: rtl/pingpong_count_ctrl.sv
// Ping-pong counter: LED walks between lo and hi, dwelling DWELL ticks at each end.
// Stepping is paced by a clock-enable tick from a power-of-two prescaler.
module pingpong_count_ctrl #(
    parameter int BASE_SHIFT = 20,
    parameter int DWELL      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       En,
    input  logic [2:0] SW,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    output logic [7:0] LED,
    output logic [7:0] Dao,
    output logic       dir,
    output logic       busy,
    output logic       tick,
    output logic [2:0] fsm_state
);

    localparam int CW = BASE_SHIFT + 7;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        DWELL_HI = 3'd2,
        DOWN     = 3'd3,
        DWELL_LO = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, pmax;
    logic [7:0]    led_n, dcnt, dcnt_n;
    logic [2:0]    sw_q;
    logic          sw_changed;

    // P-1 = 2^(BASE_SHIFT+SW)-1 is the all-ones counter width trimmed by (7-SW) bits.
    assign pmax       = {CW{1'b1}} >> (3'd7 - SW);
    assign sw_changed = (SW != sw_q);

    assign busy      = (state != IDLE);
    assign dir       = (state == IDLE) || (state == UP) || (state == DWELL_LO);
    assign tick      = busy && En && (cnt == pmax);
    assign Dao       = ~LED;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            LED   <= 8'h00;
            cnt   <= '0;
            dcnt  <= 8'h00;
            sw_q  <= 3'd0;
        end else begin
            state <= state_n;
            LED   <= led_n;
            cnt   <= cnt_n;
            dcnt  <= dcnt_n;
            sw_q  <= SW;
        end
    end

    always_comb begin
        state_n = state;
        led_n   = LED;
        cnt_n   = cnt;
        dcnt_n  = dcnt;
        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            dcnt_n  = 8'h00;
        end else if (start) begin
            state_n = UP;
            led_n   = lo;
            cnt_n   = '0;
            dcnt_n  = 8'h00;
        end else begin
            if (state == IDLE || sw_changed) begin
                cnt_n = '0;
            end else if (En) begin
                cnt_n = tick ? '0 : cnt + CW'(1);
            end
            if (tick) begin
                case (state)
                    UP: begin
                        if (LED < hi) begin
                            led_n = LED + 8'd1;
                            if (led_n == hi) state_n = DWELL_HI;
                        end else begin
                            state_n = DWELL_HI;
                        end
                    end
                    DOWN: begin
                        if (LED > lo) begin
                            led_n = LED - 8'd1;
                            if (led_n == lo) state_n = DWELL_LO;
                        end else begin
                            state_n = DWELL_LO;
                        end
                    end
                    DWELL_HI, DWELL_LO: begin
                        if (dcnt == DWELL_LAST) begin
                            state_n = (state == DWELL_HI) ? DOWN : UP;
                            dcnt_n  = 8'h00;
                        end else begin
                            dcnt_n = dcnt + 8'd1;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

endmodule
